// File: rtl/div_frac_n_prog_if.sv
// Control/status bundle for the fractional-N clock divider.
// The master drives ratio and enable; the slave returns the divided clock and status.
interface div_frac_n_prog_if #(
    parameter int CNT_W = 8
) ();
    logic             en;
    logic             load;
    logic [CNT_W-1:0] div_n;
    logic             half;
    logic             div_clk;
    logic             tick;
    logic             cfg_pend;
    logic             cfg_err;

    modport master (
        output en, load, div_n, half,
        input  div_clk, tick, cfg_pend, cfg_err
    );

    modport slave (
        input  en, load, div_n, half,
        output div_clk, tick, cfg_pend, cfg_err
    );
endinterface

// File: rtl/div_frac_n_prog.sv
// Runtime-programmable /N and /N+0.5 clock divider with boundary-aligned config updates.
// Optional macro DIV_DUTY50_EN adds a negedge flop giving 50% duty for odd integer N.
module div_frac_n_prog #(
    parameter int CNT_W    = 8,
    parameter int DEF_N    = 3,
    parameter int DEF_HALF = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    div_frac_n_prog_if.slave  io_bus
);
    localparam int CW = CNT_W + 1;  // 2N+1 needs one extra bit

    logic [CW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_act_n;
    logic [CNT_W-1:0] r_pend_n;
    logic             r_act_half;
    logic             r_pend_half;
    logic             r_pend;
    logic             r_err;
    logic             r_run;
    logic             r_a;
    logic             r_b;
    logic             r_tick;

    logic [CW-1:0]    w_len;
    logic [CW-1:0]    w_high;
    logic [CW-1:0]    w_high_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic [CNT_W-1:0] w_n_nx;
    logic             w_half_nx;
    logic             w_wrap;
    logic             w_apply;
    logic             w_run_nx;
    logic             w_illegal;

    function automatic logic [CW-1:0] high_time(input logic [CNT_W-1:0] n, input logic h);
        logic [CW-1:0] n_ext;
        n_ext = {1'b0, n};
        return h ? ((n_ext + CW'(1)) >> 1) : (n_ext >> 1);
    endfunction

    always_comb begin
        w_len     = r_act_half ? {r_act_n, 1'b1} : {1'b0, r_act_n};
        w_high    = high_time(r_act_n, r_act_half);
        w_wrap    = r_run && (r_cnt == w_len - CW'(1));
        // An idle divider has no period to protect, so a pending config lands at once.
        w_apply   = r_pend && (!r_run || w_wrap);
        w_n_nx    = w_apply ? r_pend_n    : r_act_n;
        w_half_nx = w_apply ? r_pend_half : r_act_half;
        w_run_nx  = (!r_run || w_wrap) ? io_bus.en : 1'b1;
        w_cnt_nx  = (!r_run || w_wrap) ? '0 : r_cnt + CW'(1);
        w_high_nx = high_time(w_n_nx, w_half_nx);
        w_illegal = (io_bus.div_n == '0) || ((io_bus.div_n == CNT_W'(1)) && !io_bus.half);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values; the
    // reset branch comes first so it overrides load/en in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_act_n     <= CNT_W'(DEF_N);
            r_act_half  <= 1'(DEF_HALF);
            r_pend_n    <= CNT_W'(DEF_N);
            r_pend_half <= 1'(DEF_HALF);
            r_pend      <= 1'b0;
            r_err       <= 1'b0;
            r_run       <= 1'b0;
            r_a         <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nx;
            r_run      <= w_run_nx;
            r_act_n    <= w_n_nx;
            r_act_half <= w_half_nx;
            r_a        <= w_run_nx && (w_cnt_nx < w_high_nx);
            r_tick     <= w_run_nx && (w_cnt_nx == '0);
            r_err      <= io_bus.load && w_illegal;
            if (io_bus.load) begin
                r_pend      <= 1'b1;
                r_pend_n    <= w_illegal ? CNT_W'(2) : io_bus.div_n;
                r_pend_half <= w_illegal ? 1'b0 : io_bus.half;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Second pulse of a half-mode wrap: rises mid-cycle at cnt==N, lasts H periods.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_b <= 1'b0;
        end else begin
            r_b <= r_run && r_act_half && (r_cnt >= {1'b0, r_act_n})
                   && (r_cnt < {1'b0, r_act_n} + w_high);
        end
    end

`ifdef DIV_DUTY50_EN
    logic r_ext;

    // Half-cycle stretch of pulse A for odd integer N.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_ext <= 1'b0;
        end else begin
            r_ext <= r_run && !r_act_half && r_act_n[0] && (r_cnt == w_high - CW'(1));
        end
    end

    assign io_bus.div_clk = r_a | (r_run & (r_b | r_ext));
`else
    assign io_bus.div_clk = r_a | (r_run & r_b);
`endif

    assign io_bus.tick     = r_tick;
    assign io_bus.cfg_pend = r_pend;
    assign io_bus.cfg_err  = r_err;
endmodule
